// File: rtl/relu_share_arbiter.sv
// relu_share_arbiter: round-robin shared ReLU/saturation stage; RELU_SHARE_ARBITER_SAT_COUNT_EN adds sat_count
module relu_share_arbiter #(
  parameter int data_width = 16,
  parameter int NUM_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*2*data_width-1:0] req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  output logic [data_width-1:0]           out_data,
  output logic [IDX_W-1:0]                out_idx,
  input  logic                            out_ready,
  output logic                            busy
`ifdef RELU_SHARE_ARBITER_SAT_COUNT_EN
  ,output logic [15:0]                    sat_count
`endif
);
  localparam int W2 = 2 * data_width;
  logic                  out_valid_q, out_valid_d;
  logic [data_width-1:0] out_data_q, out_data_d, act;
  logic [IDX_W-1:0]      out_idx_q, out_idx_d, rr_ptr_q, rr_ptr_d, gnt;
  logic                  found, accept, neg, sat;
  logic [W2-1:0]         x;
  function automatic logic [IDX_W-1:0] wrap(input logic [IDX_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    return IDX_W'(s >= NUM_REQ ? s - NUM_REQ : s);
  endfunction
  // first valid requester strictly after the last grant, wrapping
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[wrap(rr_ptr_q, k)]) begin
        found = 1'b1;
        gnt = wrap(rr_ptr_q, k);
      end
    end
  end
  assign x = req_data[int'(gnt)*W2 +: W2];
  assign neg = x[W2-1];
  // bit data_width-1 included so 2^(data_width-1) saturates instead of wrapping negative
  assign sat = |x[W2-2:data_width-1];
  assign act = neg ? '0 : sat ? {1'b0, {(data_width-1){1'b1}}} : x[data_width-1:0];
  assign accept = rst_n && found && (!out_valid_q || out_ready);
  assign req_ready = accept ? NUM_REQ'(1) << gnt : '0;
  always_comb begin
    out_valid_d = accept || (out_valid_q && !out_ready);
    out_data_d = accept ? act : out_data_q;
    out_idx_d = accept ? gnt : out_idx_q;
    rr_ptr_d = accept ? gnt : rr_ptr_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_idx_q <= '0;
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_idx_q <= out_idx_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_idx = out_idx_q;
  assign busy = out_valid_q || (|req_valid);
`ifdef RELU_SHARE_ARBITER_SAT_COUNT_EN
  logic [15:0] sat_count_q, sat_count_d;
  always_comb begin
    sat_count_d = (accept && !neg && sat && sat_count_q != 16'hFFFF) ? sat_count_q + 16'd1 : sat_count_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) sat_count_q <= '0;
    else sat_count_q <= sat_count_d;
  end
  assign sat_count = sat_count_q;
`endif
endmodule

// File: tb/tb_relu_share_arbiter.sv
// tb_relu_share_arbiter: scoreboard bench for relu_share_arbiter with directed corners and random traffic
module tb_relu_share_arbiter;
  localparam int DW = 16, N = 4, IW = 2, W2 = 32;
  localparam int MAXO = (1 << (DW - 1)) - 1;
  logic clk = 1'b0, rst_n = 1'b0, out_ready = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*W2-1:0] req_data = '0;
  logic out_valid, busy;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
`ifdef RELU_SHARE_ARBITER_SAT_COUNT_EN
  logic [15:0] sat_count;
`endif
  relu_share_arbiter #(.data_width(DW), .NUM_REQ(N), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_idx(out_idx), .out_ready(out_ready), .busy(busy)
`ifdef RELU_SHARE_ARBITER_SAT_COUNT_EN
    , .sat_count(sat_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int idx; int data;} item_t;
  item_t sb[$];
  int log_idx[$], log_data[$];
  int checks = 0, errors = 0, last = N - 1, exp_sat = 0;
  bit pend = 0, pend_rst = 1, pend_sat = 0, mon_en = 0;
  item_t pend_item;
  task automatic check(input string name, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act_v, exp_v, $time);
    end
  endtask
  // ReLU then clamp to the largest positive output sample
  function automatic int ref_act(input logic signed [W2-1:0] x);
    longint v;
    v = x;
    if (v < 0) return 0;
    if (v > MAXO) return MAXO;
    return int'(v);
  endfunction
  function automatic logic [N*W2-1:0] mk(input logic [W2-1:0] a, b, c, e);
    return {e, c, b, a};
  endfunction
  function automatic logic [W2-1:0] rword();
    int s;
    s = $urandom_range(0, 3);
    if (s == 0) return W2'($urandom);
    if (s == 1) return W2'($urandom_range(0, MAXO));
    if (s == 2) return W2'(MAXO - 8 + $urandom_range(0, 16));
    return W2'(-$urandom_range(0, 5));
  endfunction
  function automatic logic [N*W2-1:0] rdata();
    return mk(rword(), rword(), rword(), rword());
  endfunction
  task automatic step(input bit rstn, input logic [N-1:0] v, input logic [N*W2-1:0] d, input bit rdy);
    int g;
    logic [N-1:0] er;
    logic signed [W2-1:0] x;
    @(posedge clk);
    #1;
    if (pend_rst) begin
      sb.delete();
      last = N - 1;
      exp_sat = 0;
    end else if (pend) begin
      sb.push_back(pend_item);
      last = pend_item.idx;
      if (pend_sat && exp_sat < 65535) exp_sat++;
    end
    pend = 0;
    pend_rst = !rstn;
    rst_n = rstn;
    req_valid = v;
    req_data = d;
    out_ready = rdy;
    #1;
    g = -1;
    er = '0;
    for (int k = 1; k <= N; k++) if (g < 0 && v[(last + k) % N]) g = (last + k) % N;
    if (rstn && (sb.size() == 0 || rdy) && g >= 0) begin
      er[g] = 1'b1;
      x = d[g*W2 +: W2];
      pend = 1;
      pend_item.idx = g;
      pend_item.data = ref_act(x);
      pend_sat = x > MAXO;
    end
    check("req_ready", req_ready, er);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, '0, '0, 1);
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (mon_en) begin
        check("out_valid", out_valid, sb.size() != 0);
        check("busy", busy, (sb.size() != 0) || (|req_valid));
`ifdef RELU_SHARE_ARBITER_SAT_COUNT_EN
        check("sat_count", sat_count, exp_sat);
`endif
        if (out_valid && sb.size() != 0) begin
          check("out_data", out_data, sb[0].data);
          check("out_idx", out_idx, sb[0].idx);
          if (out_ready) begin
            log_idx.push_back(int'(out_idx));
            log_data.push_back(int'(out_data));
            void'(sb.pop_front());
          end
        end
      end
    end
  end
  initial begin
    step(0, '0, '0, 0);
    step(0, '0, '0, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_idx", out_idx, 0);
    mon_en = 1;
    step(1, 4'b0001, mk(32'h0000_1234, 0, 0, 0), 1);
    check("single_ready", req_ready, 4'b0001);
    idle(2);
    check("single_log", log_data.size() == 1 ? log_data[0] : -1, 32'h1234);
    log_idx.delete(); log_data.delete();
    step(1, 4'b0001, mk(32'hFFFF_FFFF, 0, 0, 0), 1);
    step(1, 4'b0001, mk(32'h0000_8000, 0, 0, 0), 1);
    step(1, 4'b0001, mk(32'h0001_0000, 0, 0, 0), 1);
    step(1, 4'b0001, mk(32'h0000_7FFF, 0, 0, 0), 1);
    step(1, 4'b0001, mk(32'h8000_0000, 0, 0, 0), 1);
    idle(2);
    begin : corners
      int e[5] = '{0, 32'h7FFF, 32'h7FFF, 32'h7FFF, 0};
      check("corner_count", log_data.size(), 5);
      for (int i = 0; i < 5; i++) check("corner_data", log_data.size() > i ? log_data[i] : -1, e[i]);
`ifdef RELU_SHARE_ARBITER_SAT_COUNT_EN
      check("corner_sat_count", sat_count, 2);
`endif
    end
    step(0, '0, '0, 0);
    log_idx.delete(); log_data.delete();
    for (int i = 0; i < 5; i++) step(1, 4'b1111, rdata(), 1);
    idle(2);
    begin : rr
      int e[5] = '{0, 1, 2, 3, 0};
      check("rr_count", log_idx.size(), 5);
      for (int i = 0; i < 5; i++) check("rr_idx", log_idx.size() > i ? log_idx[i] : -1, e[i]);
    end
    step(1, 4'b0110, rdata(), 1);
    check("bp_first_grant", req_ready, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'b0110, rdata(), 0);
      check("bp_stall_ready", req_ready, 4'b0000);
    end
    step(1, 4'b0110, rdata(), 1);
    check("bp_release_grant", req_ready, 4'b0100);
    step(1, 4'b1111, rdata(), 1);
    step(0, 4'b1010, rdata(), 1);
    step(1, 4'b1010, rdata(), 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_grant", req_ready, 4'b0010);
    step(1, 4'b1011, rdata(), 1);
    check("dropout_grant", req_ready, 4'b1000);
    idle(3);
    check("busy_idle", busy, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 39) != 0, N'($urandom), rdata(), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 20 && (sb.size() != 0 || pend); i++) idle(1);
    idle(1);
    check("drain_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/relu_share_arbiter.md
Name: relu_share_arbiter

Overview:
- Shares one ReLU/saturation activation stage among NUM_REQ neuron accumulators.
- Each neuron presents a full-width (2*data_width) signed accumulator result with a valid/ready handshake.
- A round-robin arbiter grants one neuron per cycle and registers the activated, tagged result.
- Sits between the per-neuron MAC accumulators and the layer output buffer.

Parameters:
- data_width, 16, output sample width; accumulator inputs are 2*data_width bits, two's complement.
- NUM_REQ, 4, number of neuron requesters (at least 2).
- IDX_W, 2, width of the requester index, equal to clog2(NUM_REQ).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NUM_REQ  bit i: accumulator i holds a result.
- req_data  in  NUM_REQ*2*data_width  slice i is bits [(i+1)*2*data_width-1 : i*2*data_width].
- req_ready  out  NUM_REQ  one-hot grant/accept strobe, combinational.
- out_valid  out  1  out_data and out_idx are valid.
- out_data  out  data_width  activated result.
- out_idx  out  IDX_W  index of the requester that produced out_data.
- out_ready  in  1  downstream accepts the output this cycle.
- busy  out  1  out_valid OR any req_valid.

Behaviour:
- Reset, sampled on a clk edge with rst_n=0:
  - out_valid=0, out_data=0, out_idx=0.
  - rr_ptr=NUM_REQ-1, so the first grant after reset goes to index 0.
  - Reset mid-transfer discards the held output; no req_ready is asserted in that cycle.
- Output register state:
  - EMPTY when out_valid=0; FULL when out_valid=1.
  - can_accept = !out_valid || out_ready.
- Arbitration:
  - Candidates are the req_valid bits, searched starting at rr_ptr+1 and wrapping modulo NUM_REQ.
  - The first asserted bit is index g.
  - req_ready[g]=1 only when can_accept and req_valid[g]; all other bits are 0.
  - req_ready is 0 for every requester while rst_n=0.
- Accept edge (req_ready[g]=1):
  - out_data <= act(req_data slice g); out_idx <= g; out_valid <= 1; rr_ptr <= g.
- Drain without refill: out_valid && out_ready && no req_valid -> out_valid <= 0. out_data and out_idx hold their values.
- Stall: out_valid && !out_ready -> all registers hold; req_ready is all 0.
- Throughput and latency:
  - Back-to-back drain and refill in the same cycle, one result per clock, no bubble.
  - Latency is 1 clock from accept to out_valid.
- Activation act(x), x of width W2 = 2*data_width:
  - x[W2-1]=1 (negative) -> 0.
  - Otherwise, if any bit of x[W2-2 : data_width-1] is set -> saturate to 0x7FFF for data_width=16 (0 followed by data_width-1 ones).
  - Otherwise -> x[data_width-1:0].
  - The check includes bit data_width-1, so values 2^(data_width-1) and above saturate rather than wrap negative.
- Fairness: a continuously asserted requester waits at most NUM_REQ-1 accepts.
- req_valid may drop without being granted; the arbiter simply skips that requester.

Optional Feature:
- Macro: RELU_SHARE_ARBITER_SAT_COUNT_EN.
- Defined:
  - Adds output port sat_count, 16 bits.
  - Increments on each accept whose act() result took the saturate branch.
  - Sticks at 0xFFFF and does not wrap.
  - Cleared by reset.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then single request: req_valid=0001, req_data[0]=0x0000_1234, out_ready=1 -> req_ready=0001 for one cycle; next cycle out_valid=1, out_data=0x1234, out_idx=0.
- Activation corners, one accept each:
  - 0xFFFF_FFFF -> 0x0000.
  - 0x0000_8000 -> 0x7FFF.
  - 0x0001_0000 -> 0x7FFF.
  - 0x0000_7FFF -> 0x7FFF, no saturation count.
  - 0x8000_0000 -> 0x0000.
  - With RELU_SHARE_ARBITER_SAT_COUNT_EN, sat_count=2 after these five.
- Round-robin: req_valid=1111 held, out_ready=1 -> out_idx sequence 0,1,2,3,0 on consecutive cycles, out_valid continuously 1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with req_valid=0110 -> out_data/out_idx stable and req_ready=0000; on release, the next grant goes to the index after rr_ptr.
- Reset mid-stream: rst_n=0 for one edge while FULL with requests pending -> out_valid=0 next cycle; after release, the first grant goes to the lowest-indexed active requester (req_valid=1010 -> idx 1).
- Drop-out: req_valid[2] deasserted before its turn -> grant skips 2; no X on out_data; busy falls to 0 once out_valid is drained and no req_valid remains.
